// File: rtl/ex_pkg.sv
// ex_pkg
//  Shared constants and types for the EX stage with iterative mul/div:
//  datapath width, ALUOp encodings, R-type function codes and the
//  mul/div sequencer state type.
package ex_pkg;

   localparam int EX_XLEN      = 32;
   localparam int EX_MD_CYCLES = 32;

   // ALUOp from the ID/EX control field EX_in[2:1]
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   // R-type function codes
   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_SLT   = 6'h2A;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//  Iterative unsigned multiplier (shift-add) and, when EX_MULDIV_DIV_EN is
//  defined, restoring divider. One step per clock for MD_CYCLES cycles;
//  HI/LO are written on the final step.
//  Config macro: EX_MULDIV_DIV_EN (divider present when defined).
// Ports
//  clk     in   rising-edge clock
//  rst     in   synchronous active-high reset (aborts any operation)
//  start   in   a multu/divu is presented; sampled only in IDLE
//  is_div  in   1 = divu, 0 = multu (ignored without the divider)
//  a, b    in   operands, captured on the start edge
//  busy    out  operation in progress (RUN)
//  done    out  result just written to HI/LO (DONE, one cycle)
//  hi, lo  out  architectural HI/LO registers
//
// state | meaning
// IDLE  | waiting; start captures operands and arms the down-counter
// RUN   | one iteration per cycle; terminal count writes HI/LO
// DONE  | result visible, issuing instruction leaves ID/EX; no re-issue
module muldiv_unit
   import ex_pkg::*;
#(
   parameter int XLEN      = EX_XLEN,
   parameter int MD_CYCLES = EX_MD_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_div,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(MD_CYCLES);
   localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 1);

   md_state_t       state, state_nxt;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] acc_hi, acc_lo, opnd;
   logic [XLEN-1:0] step_hi, step_lo;
   logic [XLEN:0]   mul_sum;

`ifdef EX_MULDIV_DIV_EN
   logic          op_div;
   logic [XLEN:0] div_sh, div_diff;
   logic          div_ge;
`else
   logic          unused_is_div;
   assign unused_is_div = is_div;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         hi     <= '0;
         lo     <= '0;
`ifdef EX_MULDIV_DIV_EN
         op_div <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  // Same register layout for both ops: acc_lo holds the
                  // multiplier / dividend, acc_hi the partial product / remainder.
                  acc_hi <= '0;
                  acc_lo <= a;
                  opnd   <= b;
                  count  <= CNT_LOAD;
`ifdef EX_MULDIV_DIV_EN
                  op_div <= is_div;
`endif
               end
            end
            RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count - 1'b1;
               if (count == '0) begin
                  hi <= step_hi;
                  lo <= step_lo;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      // Shift-add: add multiplicand when the low multiplier bit is set,
      // then shift the 65-bit {carry, acc_hi, acc_lo} right by one.
      mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
`ifdef EX_MULDIV_DIV_EN
      // Restoring step. A zero divisor always "fits", so the quotient
      // fills with ones and the remainder ends up equal to the dividend.
      div_sh   = {acc_hi, acc_lo[XLEN-1]};
      div_diff = div_sh - {1'b0, opnd};
      div_ge   = (div_sh >= {1'b0, opnd});
      if (op_div) begin
         step_hi = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
         step_lo = {acc_lo[XLEN-2:0], div_ge};
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (count == '0) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage
//  Execute stage between ID/EX and EX/MEM: single-cycle ALU plus an
//  iterative multu/divu unit writing HI/LO. While the unit runs, stall
//  holds PC, IF/ID and ID/EX, and a bubble is sent to EX/MEM.
//  Config macro: EX_MULDIV_DIV_EN (divu supported when defined; otherwise
//  funct 1B behaves as an unknown function code).
// Ports
//  clk, rst            clock, synchronous active-high reset
//  WB_in, MEM_in       pipeline controls, gated to 0 while stalled / in DONE
//  EX_in               [3]RegDst [2:1]ALUOp [0]ALUSrc
//  shamt_in, funct_in  shift amount, R-type function code
//  RD1_in, RD2_in      operands A and B (B also store data)
//  immed_in            sign-extended immediate
//  rt_in, rd_in        destination candidates
//  WB_out, MEM_out     controls to EX/MEM
//  alu_out, zero_out   result and result==0
//  wdata_out           store data
//  wreg_out            destination register index
//  stall               1 = hold upstream
module ex_muldiv_stage
   import ex_pkg::*;
#(
   parameter int XLEN      = EX_XLEN,
   parameter int MD_CYCLES = EX_MD_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      WB_in,
   input  logic [1:0]      MEM_in,
   input  logic [3:0]      EX_in,
   input  logic [4:0]      shamt_in,
   input  logic [5:0]      funct_in,
   input  logic [XLEN-1:0] RD1_in,
   input  logic [XLEN-1:0] RD2_in,
   input  logic [XLEN-1:0] immed_in,
   input  logic [4:0]      rt_in,
   input  logic [4:0]      rd_in,
   output logic [1:0]      WB_out,
   output logic [1:0]      MEM_out,
   output logic [XLEN-1:0] alu_out,
   output logic [XLEN-1:0] wdata_out,
   output logic [4:0]      wreg_out,
   output logic            zero_out,
   output logic            stall
);

   logic [1:0]      alu_op;
   logic [XLEN-1:0] op_b, alu_res, hi, lo;
   logic            is_md, is_div, md_busy, md_done, md_idle, bubble;

   assign alu_op = EX_in[2:1];
   assign op_b   = EX_in[0] ? immed_in : RD2_in;
   assign is_div = (funct_in == F_DIVU);

`ifdef EX_MULDIV_DIV_EN
   assign is_md = (alu_op == ALUOP_RTYPE) && ((funct_in == F_MULTU) || is_div);
`else
   assign is_md = (alu_op == ALUOP_RTYPE) && (funct_in == F_MULTU);
`endif

   muldiv_unit #(
      .XLEN      (XLEN),
      .MD_CYCLES (MD_CYCLES)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (is_md),
      .is_div (is_div),
      .a      (RD1_in),
      .b      (RD2_in),
      .busy   (md_busy),
      .done   (md_done),
      .hi     (hi),
      .lo     (lo)
   );

   // Stall covers the issue cycle (combinational) plus every RUN cycle.
   // DONE drops the stall but still bubbles: multu/divu never write a GPR.
   assign md_idle = ~md_busy & ~md_done;
   assign stall   = md_busy | (md_idle & is_md);
   assign bubble  = stall | md_done;

   always_comb begin
      alu_res = '0;
      case (alu_op)
         ALUOP_ADD: alu_res = RD1_in + op_b;
         ALUOP_SUB: alu_res = RD1_in - op_b;
         ALUOP_OR:  alu_res = RD1_in | op_b;
         default: begin
            case (funct_in)
               F_ADD:  alu_res = RD1_in + op_b;
               F_SUB:  alu_res = RD1_in - op_b;
               F_AND:  alu_res = RD1_in & op_b;
               F_OR:   alu_res = RD1_in | op_b;
               F_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(RD1_in) < $signed(op_b))};
               F_SLL:  alu_res = op_b << shamt_in;
               F_SRL:  alu_res = op_b >> shamt_in;
               F_MFHI: alu_res = hi;
               F_MFLO: alu_res = lo;
               default: alu_res = '0;
            endcase
         end
      endcase
   end

   assign alu_out   = alu_res;
   assign zero_out  = (alu_res == '0);
   assign wdata_out = RD2_in;
   assign wreg_out  = EX_in[3] ? rd_in : rt_in;
   assign WB_out    = bubble ? 2'b00 : WB_in;
   assign MEM_out   = bubble ? 2'b00 : MEM_in;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
module tb_ex_muldiv_stage;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  WB_in, MEM_in, WB_out, MEM_out;
   logic [3:0]  EX_in;
   logic [4:0]  shamt_in, rt_in, rd_in, wreg_out;
   logic [5:0]  funct_in;
   logic [31:0] RD1_in, RD2_in, immed_in, alu_out, wdata_out;
   logic        zero_out, stall;

   int checks = 0;
   int errors = 0;
   int n_stall, n_bad;

   ex_muldiv_stage dut (
      .clk       (clk),
      .rst       (rst),
      .WB_in     (WB_in),
      .MEM_in    (MEM_in),
      .EX_in     (EX_in),
      .shamt_in  (shamt_in),
      .funct_in  (funct_in),
      .RD1_in    (RD1_in),
      .RD2_in    (RD2_in),
      .immed_in  (immed_in),
      .rt_in     (rt_in),
      .rd_in     (rd_in),
      .WB_out    (WB_out),
      .MEM_out   (MEM_out),
      .alu_out   (alu_out),
      .wdata_out (wdata_out),
      .wreg_out  (wreg_out),
      .zero_out  (zero_out),
      .stall     (stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
      WB_in    = 2'b11;
      MEM_in   = 2'b10;
      EX_in    = {1'b1, ALUOP_RTYPE, 1'b0};
      funct_in = f;
      RD1_in   = a;
      RD2_in   = b;
      shamt_in = sh;
      immed_in = 32'h0000_0055;
      rt_in    = 5'd3;
      rd_in    = 5'd9;
   endtask

   task automatic drive_i(input logic [1:0] op, input logic src, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm);
      WB_in    = 2'b11;
      MEM_in   = 2'b10;
      EX_in    = {1'b0, op, src};
      funct_in = 6'h3F;
      RD1_in   = a;
      RD2_in   = b;
      shamt_in = 5'd0;
      immed_in = imm;
      rt_in    = 5'd3;
      rd_in    = 5'd9;
   endtask

   // Issue a multi-cycle op and count stalled cycles (issue + RUN), noting
   // any cycle where the bubble is missing. Operands are scrambled after
   // issue. Returns sampling mid-cycle in the first non-stalled cycle.
   task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int n, output int bad);
      drive_r(f, a, b, 5'd0);
      n   = 0;
      bad = 0;
      #4;
      while (stall === 1'b1 && n < 40) begin
         if (WB_out !== 2'b00 || MEM_out !== 2'b00) bad++;
         n++;
         next_cyc();
         RD1_in = 32'hDEAD_BEEF;
         RD2_in = 32'h1234_5678;
         #4;
      end
   endtask

   initial begin
      rst = 1'b1;
      drive_i(ALUOP_ADD, 1'b0, 32'd0, 32'd0, 32'd0);
      next_cyc();
      #4;
      chk("reset_stall", {31'd0, stall}, 32'd0);
      next_cyc();
      rst = 1'b0;
      drive_r(F_MFHI, 32'd0, 32'd0, 5'd0);
      #4;
      chk("reset_hi", alu_out, 32'd0);

      next_cyc();
      drive_r(F_ADD, 32'd5, 32'd7, 5'd0);
      #4;
      chk("add_res", alu_out, 32'd12);
      chk("add_wreg", {27'd0, wreg_out}, 32'd9);
      chk("add_zero", {31'd0, zero_out}, 32'd0);
      chk("add_stall", {31'd0, stall}, 32'd0);
      chk("add_wb", {30'd0, WB_out}, 32'd3);
      chk("add_mem", {30'd0, MEM_out}, 32'd2);
      chk("add_wdata", wdata_out, 32'd7);

      next_cyc();
      drive_i(ALUOP_SUB, 1'b0, 32'd9, 32'd9, 32'd0);
      #4;
      chk("beq_res", alu_out, 32'd0);
      chk("beq_zero", {31'd0, zero_out}, 32'd1);
      chk("beq_wreg", {27'd0, wreg_out}, 32'd3);

      next_cyc();
      drive_r(F_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
      #4;
      chk("slt_neg", alu_out, 32'd1);
      next_cyc();
      drive_r(F_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0);
      #4;
      chk("slt_pos", alu_out, 32'd0);
      next_cyc();
      drive_r(F_AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0);
      #4;
      chk("and_res", alu_out, 32'h0000_00F0);
      next_cyc();
      drive_i(ALUOP_OR, 1'b1, 32'h0000_1000, 32'hFFFF_0000, 32'h0000_0234);
      #4;
      chk("ori_res", alu_out, 32'h0000_1234);
      next_cyc();
      drive_r(F_SLL, 32'd0, 32'd1, 5'd31);
      #4;
      chk("sll_res", alu_out, 32'h8000_0000);
      next_cyc();
      drive_r(F_SRL, 32'd0, 32'h8000_0000, 5'd4);
      #4;
      chk("srl_res", alu_out, 32'h0800_0000);
      next_cyc();
      drive_r(F_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
      #4;
      chk("add_wrap", alu_out, 32'd0);
      chk("add_wrap_zero", {31'd0, zero_out}, 32'd1);
      next_cyc();
      drive_r(6'h3F, 32'd5, 32'd6, 5'd0);
      #4;
      chk("unknown_funct", alu_out, 32'd0);

      next_cyc();
      run_md(F_MULTU, 32'hFFFF_FFFF, 32'd2, n_stall, n_bad);
      chk("multu_stall_cycles", n_stall, 32'd33);
      chk("multu_bubble", n_bad, 32'd0);
      chk("multu_done_wb", {30'd0, WB_out}, 32'd0);
      chk("multu_done_mem", {30'd0, MEM_out}, 32'd0);
      next_cyc();
      drive_r(F_MFHI, 32'd0, 32'd0, 5'd0);
      #4;
      chk("multu_hi", alu_out, 32'd1);
      chk("mfhi_wb", {30'd0, WB_out}, 32'd3);
      next_cyc();
      drive_r(F_MFLO, 32'd0, 32'd0, 5'd0);
      #4;
      chk("multu_lo", alu_out, 32'hFFFF_FFFE);

`ifdef EX_MULDIV_DIV_EN
      next_cyc();
      run_md(F_DIVU, 32'd100, 32'd7, n_stall, n_bad);
      chk("divu_stall_cycles", n_stall, 32'd33);
      chk("divu_bubble", n_bad, 32'd0);
      next_cyc();
      drive_r(F_MFLO, 32'd0, 32'd0, 5'd0);
      #4;
      chk("divu_lo", alu_out, 32'd14);
      next_cyc();
      drive_r(F_MFHI, 32'd0, 32'd0, 5'd0);
      #4;
      chk("divu_hi", alu_out, 32'd2);
      next_cyc();
      run_md(F_DIVU, 32'd5, 32'd0, n_stall, n_bad);
      chk("div0_stall_cycles", n_stall, 32'd33);
      next_cyc();
      drive_r(F_MFLO, 32'd0, 32'd0, 5'd0);
      #4;
      chk("div0_lo", alu_out, 32'hFFFF_FFFF);
      next_cyc();
      drive_r(F_MFHI, 32'd0, 32'd0, 5'd0);
      #4;
      chk("div0_hi", alu_out, 32'd5);
`else
      next_cyc();
      drive_r(F_DIVU, 32'd100, 32'd7, 5'd0);
      #4;
      chk("nodiv_stall", {31'd0, stall}, 32'd0);
      chk("nodiv_res", alu_out, 32'd0);
      chk("nodiv_wb", {30'd0, WB_out}, 32'd3);
      next_cyc();
      #4;
      chk("nodiv_stall2", {31'd0, stall}, 32'd0);
      next_cyc();
      drive_r(F_MFHI, 32'd0, 32'd0, 5'd0);
      #4;
      chk("nodiv_hi", alu_out, 32'd1);
      next_cyc();
      drive_r(F_MFLO, 32'd0, 32'd0, 5'd0);
      #4;
      chk("nodiv_lo", alu_out, 32'hFFFF_FFFE);
`endif

      // Abort a multiply at RUN cycle 10 with a synchronous reset.
      next_cyc();
      drive_r(F_MULTU, 32'd3, 32'd4, 5'd0);
      repeat (10) next_cyc();
      #4;
      chk("abort_running", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      drive_i(ALUOP_ADD, 1'b0, 32'd2, 32'd3, 32'd0);
      #4;
      chk("abort_stall", {31'd0, stall}, 32'd0);
      chk("abort_add", alu_out, 32'd5);
      chk("abort_wb", {30'd0, WB_out}, 32'd3);
      next_cyc();
      drive_r(F_MFHI, 32'd0, 32'd0, 5'd0);
      #4;
      chk("abort_hi", alu_out, 32'd0);
      next_cyc();
      drive_r(F_MFLO, 32'd0, 32'd0, 5'd0);
      #4;
      chk("abort_lo", alu_out, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
